// File: rtl/backscatter_phase_decoder_pkg.sv
// Shared types, widths and the symbol decision rule for the backscatter phase decoder.
// The widths are derived from the default geometry; a build that enlarges
// SYMBOL_LEN, WORD_BITS or FRAME_WORDS beyond the defaults must raise them here too.
package backscatter_phase_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_ACCUM = 2'd2
  } state_t;

  localparam int SYMBOL_LEN_DEF  = 64;
  localparam int MARGIN_DEF      = 16;
  localparam int WORD_BITS_DEF   = 8;
  localparam int FRAME_WORDS_DEF = 4;

  // Agreement counter must hold SYMBOL_LEN itself without wrapping.
  localparam int CNT_W      = $clog2(SYMBOL_LEN_DEF + 1);
  localparam int BIT_W      = $clog2(WORD_BITS_DEF + 1);
  localparam int WORD_CNT_W = $clog2(FRAME_WORDS_DEF + 1);

  typedef struct packed {
    logic value;
    logic erasure;
  } decision_t;

  // Clean 1 near full agreement, clean 0 near full disagreement, otherwise an
  // erasure resolved by majority with an exact tie going to 0.
  function automatic decision_t decide(input logic [CNT_W-1:0] agree,
                                       input int sym_len,
                                       input int margin);
    decision_t d;
    int a;
    a = int'(agree);
    if (a >= sym_len - margin) begin
      d.value   = 1'b1;
      d.erasure = 1'b0;
    end else if (a <= margin) begin
      d.value   = 1'b0;
      d.erasure = 1'b0;
    end else begin
      d.value   = (a > sym_len / 2);
      d.erasure = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/backscatter_phase_decoder_symbol_correlator.sv
// Counts agreement between the observed switch drive and the reference
// subcarrier over one symbol and decides the bit on the symbol's last sample.
module backscatter_phase_decoder_symbol_correlator
  import backscatter_phase_decoder_pkg::*;
#(
  parameter int SYMBOL_LEN = SYMBOL_LEN_DEF,
  parameter int MARGIN     = MARGIN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic ref_subcarrier,
  input  logic switch_signal,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_erasure
);

  logic [CNT_W-1:0] agree_cnt_r;
  logic [CNT_W-1:0] sample_cnt_r;
  logic [CNT_W-1:0] agree_next_s;
  logic             match_s;
  logic             last_s;
  decision_t        dec_s;

  // Running agreement including the current sample, and the decision on it.
  always_comb begin
    match_s      = ~(switch_signal ^ ref_subcarrier);
    agree_next_s = agree_cnt_r + {{(CNT_W-1){1'b0}}, match_s};
    last_s       = run & (sample_cnt_r == CNT_W'(SYMBOL_LEN - 1));
    dec_s        = decide(agree_next_s, SYMBOL_LEN, MARGIN);
    bit_valid    = last_s;
    bit_value    = dec_s.value;
    bit_erasure  = dec_s.erasure;
  end

  // Symbol counters: accumulate while running, restart right after a decision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      agree_cnt_r  <= {CNT_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else if (!run || last_s) begin
      agree_cnt_r  <= {CNT_W{1'b0}};
      sample_cnt_r <= {CNT_W{1'b0}};
    end else begin
      agree_cnt_r  <= agree_next_s;
      sample_cnt_r <= sample_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/backscatter_phase_decoder.sv
// Phase-flip backscatter decoder: trigger synchronizer, frame FSM and
// MSB-first word packing around the symbol correlator.
module backscatter_phase_decoder
  import backscatter_phase_decoder_pkg::*;
#(
  parameter int SYMBOL_LEN  = SYMBOL_LEN_DEF,
  parameter int MARGIN      = MARGIN_DEF,
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 trigger_signal,
  input  logic                 ref_subcarrier,
  input  logic                 switch_signal,
  output logic [WORD_BITS-1:0] data_word,
  output logic                 word_valid,
  output logic                 word_erasure,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic                 busy
);

  state_t                state_r;
  state_t                state_next_s;
  logic                  trig_meta_r;
  logic                  trig_sync_r;
  logic                  trig_sync_d_r;
  logic                  ref_d_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic [WORD_CNT_W-1:0] word_cnt_r;
  logic [WORD_BITS-1:0]  shift_r;
  logic                  erasure_acc_r;
  logic [WORD_BITS-1:0]  data_word_r;
  logic                  word_valid_r;
  logic                  word_erasure_r;
  logic                  frame_done_r;
  logic                  frame_abort_r;
  logic                  busy_r;

  logic trig_rise_s;
  logic ref_rise_s;
  logic in_frame_s;
  logic run_s;
  logic bit_valid_s;
  logic bit_value_s;
  logic bit_erasure_s;
  logic word_done_s;
  logic frame_last_s;
  logic abort_s;

  backscatter_phase_decoder_symbol_correlator #(
    .SYMBOL_LEN (SYMBOL_LEN),
    .MARGIN     (MARGIN)
  ) u_correlator (
    .clock          (clock),
    .reset          (reset),
    .run            (run_s),
    .ref_subcarrier (ref_subcarrier),
    .switch_signal  (switch_signal),
    .bit_valid      (bit_valid_s),
    .bit_value      (bit_value_s),
    .bit_erasure    (bit_erasure_s)
  );

  // Two-flop trigger synchronizer plus edge-history of trigger and reference.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_meta_r   <= 1'b0;
      trig_sync_r   <= 1'b0;
      trig_sync_d_r <= 1'b0;
      ref_d_r       <= 1'b0;
    end else begin
      trig_meta_r   <= trigger_signal;
      trig_sync_r   <= trig_meta_r;
      trig_sync_d_r <= trig_sync_r;
      ref_d_r       <= ref_subcarrier;
    end
  end

  // Event decode; the reference edge cycle in ALIGN is already sample 0.
  always_comb begin
    trig_rise_s  = trig_sync_r & ~trig_sync_d_r;
    ref_rise_s   = ref_subcarrier & ~ref_d_r;
    in_frame_s   = (state_r != ST_IDLE);
    run_s        = (state_r == ST_ACCUM) | ((state_r == ST_ALIGN) & ref_rise_s);
    word_done_s  = bit_valid_s & (bit_cnt_r == BIT_W'(WORD_BITS - 1));
    frame_last_s = word_done_s & (word_cnt_r == WORD_CNT_W'(FRAME_WORDS - 1));
    // A frame finishing on the same cycle the trigger falls is not an abort.
    abort_s      = in_frame_s & ~trig_sync_r & ~frame_last_s;
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_rise_s) begin
          state_next_s = ST_ALIGN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        if (abort_s) begin
          state_next_s = ST_IDLE;
        end else if (ref_rise_s) begin
          state_next_s = ST_ACCUM;
        end else begin
          state_next_s = ST_ALIGN;
        end
      end
      ST_ACCUM: begin
        if (frame_last_s || abort_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Bit/word counters, erasure accumulation and the MSB-first shift register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_r     <= {BIT_W{1'b0}};
      word_cnt_r    <= {WORD_CNT_W{1'b0}};
      shift_r       <= {WORD_BITS{1'b0}};
      erasure_acc_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      bit_cnt_r     <= {BIT_W{1'b0}};
      word_cnt_r    <= {WORD_CNT_W{1'b0}};
      erasure_acc_r <= 1'b0;
    end else if (bit_valid_s) begin
      shift_r <= {shift_r[WORD_BITS-2:0], bit_value_s};
      if (word_done_s) begin
        bit_cnt_r     <= {BIT_W{1'b0}};
        erasure_acc_r <= 1'b0;
        word_cnt_r    <= frame_last_s ? {WORD_CNT_W{1'b0}} : (word_cnt_r + WORD_CNT_W'(1));
      end else begin
        bit_cnt_r     <= bit_cnt_r + BIT_W'(1);
        erasure_acc_r <= erasure_acc_r | bit_erasure_s;
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  // Registered outputs; data_word and word_erasure hold between word pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_word_r    <= {WORD_BITS{1'b0}};
      word_valid_r   <= 1'b0;
      word_erasure_r <= 1'b0;
      frame_done_r   <= 1'b0;
      frame_abort_r  <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      word_valid_r  <= word_done_s;
      frame_done_r  <= frame_last_s;
      frame_abort_r <= abort_s;
      busy_r        <= in_frame_s;
      if (word_done_s) begin
        data_word_r    <= {shift_r[WORD_BITS-2:0], bit_value_s};
        word_erasure_r <= erasure_acc_r | bit_erasure_s;
      end else begin
        data_word_r    <= data_word_r;
        word_erasure_r <= word_erasure_r;
      end
    end
  end

  assign data_word    = data_word_r;
  assign word_valid   = word_valid_r;
  assign word_erasure = word_erasure_r;
  assign frame_done   = frame_done_r;
  assign frame_abort  = frame_abort_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_backscatter_phase_decoder.sv
// Directed bench for backscatter_phase_decoder with default geometry
// (64-sample symbols, margin 16, 8-bit words, 4-word frames).
// The reference subcarrier has an 8-cycle period; frames are started just
// after a reference rising edge so decoding must lock to the following edge.
module tb_backscatter_phase_decoder;

  logic       clock;
  logic       reset;
  logic       trigger_signal;
  logic       ref_subcarrier;
  logic       switch_signal;
  logic [7:0] data_word;
  logic       word_valid;
  logic       word_erasure;
  logic       frame_done;
  logic       frame_abort;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int ph       = 0;
  int wv_cnt   = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  backscatter_phase_decoder dut (
    .clock          (clock),
    .reset          (reset),
    .trigger_signal (trigger_signal),
    .ref_subcarrier (ref_subcarrier),
    .switch_signal  (switch_signal),
    .data_word      (data_word),
    .word_valid     (word_valid),
    .word_erasure   (word_erasure),
    .frame_done     (frame_done),
    .frame_abort    (frame_abort),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (word_valid === 1'b1) wv_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (frame_abort === 1'b1) abort_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One sample: reference from the local phase, switch = ref for 1, ~ref for 0,
  // optionally inverted to model a corrupted sample.
  task automatic tick(input bit b, input bit cor);
    bit r;
    @(negedge clock);
    r = (ph < 4);
    ref_subcarrier = r;
    switch_signal  = (b ? r : ~r) ^ cor;
    ph = (ph + 1) % 8;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    trigger_signal = 1'b0;
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0);
  endtask

  // Raise the trigger while the reference is high; the symbol then starts on
  // the reference rising edge eight cycles later.
  task automatic start_frame();
    while (ph != 1) tick(1'b1, 1'b0);
    trigger_signal = 1'b1;
    for (int k = 0; k < 7; k++) tick(1'b0, 1'b0);
    check_eq("busy_in_align", busy, 1);
  endtask

  // Send one word; bit cor_bit gets ncor corrupted samples (10..10+ncor-1).
  // drop clears the trigger so the synchronized trigger is low on the word's
  // final sample. Outputs are checked right after that final sample's edge.
  task automatic send_word(input string tag, input logic [7:0] w, input int cor_bit,
                           input int ncor, input bit drop, input bit last,
                           input logic [7:0] exp_w, input bit exp_e);
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 64; i++) begin
        if (drop && j == 7 && i == 61) trigger_signal = 1'b0;
        tick(w[7-j], (j == cor_bit) && (i >= 10) && (i < 10 + ncor));
      end
    end
    check_eq({tag, "_valid"}, word_valid, 1);
    check_eq({tag, "_data"}, data_word, exp_w);
    check_eq({tag, "_erasure"}, word_erasure, exp_e);
    check_eq({tag, "_done"}, frame_done, last);
    check_eq({tag, "_abort"}, frame_abort, drop && !last);
  endtask

  task automatic send_bits(input logic [7:0] w, input int nbits);
    for (int j = 0; j < nbits; j++)
      for (int i = 0; i < 64; i++) tick(w[7-j], 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"}, data_word, 0);
    check_eq({tag, "_valid"}, word_valid, 0);
    check_eq({tag, "_erasure"}, word_erasure, 0);
    check_eq({tag, "_done"}, frame_done, 0);
    check_eq({tag, "_abort"}, frame_abort, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wv0, dn0, ab0;
    reset = 1'b0;
    trigger_signal = 1'b0;
    ref_subcarrier = 1'b0;
    switch_signal  = 1'b0;
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);
    check_all_zero("reset");
    reset = 1'b1;
    idle(5);

    // Clean frame.
    wv0 = wv_cnt; dn0 = done_cnt; ab0 = abort_cnt;
    start_frame();
    send_word("clean0", 8'hA5, -1, 0, 1'b0, 1'b0, 8'hA5, 1'b0);
    send_word("clean1", 8'h3C, -1, 0, 1'b0, 1'b0, 8'h3C, 1'b0);
    send_word("clean2", 8'hFF, -1, 0, 1'b0, 1'b0, 8'hFF, 1'b0);
    send_word("clean3", 8'h00, -1, 0, 1'b0, 1'b1, 8'h00, 1'b0);
    check_eq("clean_busy_at_done", busy, 1);
    tick(1'b1, 1'b0);
    check_eq("clean_busy_after", busy, 0);
    check_eq("clean_done_pulse", frame_done, 0);
    check_eq("clean_hold_data", data_word, 8'h00);
    // Trigger still high: no restart without a fresh rise.
    for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
    check_eq("no_restart_busy", busy, 0);
    check_eq("clean_wv_count", wv_cnt - wv0, 4);
    check_eq("clean_done_count", done_cnt - dn0, 1);
    check_eq("clean_abort_count", abort_cnt - ab0, 0);

    // Erasure thresholds; trigger drops exactly on the frame's final decision.
    idle(5);
    ab0 = abort_cnt;
    start_frame();
    send_word("a44", 8'hFF, 2, 20, 1'b0, 1'b0, 8'hFF, 1'b1);
    send_word("a32", 8'hFF, 0, 32, 1'b0, 1'b0, 8'h7F, 1'b1);
    send_word("a48", 8'h80, 0, 16, 1'b0, 1'b0, 8'h80, 1'b0);
    send_word("drop_final", 8'h0F, 7, 20, 1'b1, 1'b1, 8'h0F, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    check_eq("drop_final_no_abort", abort_cnt - ab0, 0);
    check_eq("drop_final_busy", busy, 0);

    // Trigger drops on a non-final word completion: word and abort together.
    idle(5);
    ab0 = abort_cnt;
    start_frame();
    send_word("drop_word0", 8'h12, -1, 0, 1'b1, 1'b0, 8'h12, 1'b0);
    idle(5);
    check_eq("drop_word0_abort_count", abort_cnt - ab0, 1);
    check_eq("drop_word0_busy", busy, 0);

    // Abort after 13 bits.
    idle(5);
    wv0 = wv_cnt; ab0 = abort_cnt;
    start_frame();
    send_word("ab_w0", 8'h5A, -1, 0, 1'b0, 1'b0, 8'h5A, 1'b0);
    send_bits(8'h00, 5);
    idle(10);
    check_eq("abort_count", abort_cnt - ab0, 1);
    check_eq("abort_wv_count", wv_cnt - wv0, 1);
    check_eq("abort_hold_data", data_word, 8'h5A);
    check_eq("abort_busy", busy, 0);

    // Asynchronous reset in the middle of ACCUM, then a full clean frame.
    idle(5);
    start_frame();
    send_word("rst_w0", 8'hC3, -1, 0, 1'b0, 1'b0, 8'hC3, 1'b0);
    send_bits(8'hF0, 2);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    reset = 1'b1;
    idle(5);
    wv0 = wv_cnt;
    start_frame();
    send_word("post0", 8'h01, -1, 0, 1'b0, 1'b0, 8'h01, 1'b0);
    send_word("post1", 8'h80, -1, 0, 1'b0, 1'b0, 8'h80, 1'b0);
    send_word("post2", 8'h7E, -1, 0, 1'b0, 1'b0, 8'h7E, 1'b0);
    send_word("post3", 8'h55, -1, 0, 1'b0, 1'b1, 8'h55, 1'b0);
    idle(3);
    check_eq("post_wv_count", wv_cnt - wv0, 4);
    check_eq("post_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/backscatter_phase_decoder.md
Name: backscatter_phase_decoder

Overview:
- Receive-side counterpart of the tag's phase-flip backscatter modulator. The modulator sends the subcarrier as-is for a data bit of 1 and inverted for a data bit of 0, during the trigger window.
- The block samples the switch-drive waveform against a local reference subcarrier and counts agreement per symbol. It decides each bit by threshold, packs bits into bytes and reports frame completion or abort.
- Used for on-board loopback verification and as the bench-side decoder for tag bring-up.

Parameters:
- SYMBOL_LEN, 64: sample-clock cycles per data bit; must be ≥ 4 and even.
- MARGIN, 16: agreement distance from the extremes still accepted as a clean bit; must be < SYMBOL_LEN/2.
- WORD_BITS, 8: bits per output word.
- FRAME_WORDS, 4: words per frame.

Ports:
- clock  in  1  sampling clock, same domain as the subcarrier generator
- reset  in  1  asynchronous, active-low reset
- trigger_signal  in  1  frame window from the tag side; asynchronous, so it passes through a 2-flop synchronizer
- ref_subcarrier  in  1  local reference square wave, synchronous to clock
- switch_signal  in  1  observed switch-drive waveform, synchronous to clock
- data_word  out  WORD_BITS  last completed word, MSB = first received bit
- word_valid  out  1  one-cycle pulse when data_word updates
- word_erasure  out  1  valid with word_valid; 1 if any bit in that word was ambiguous
- frame_done  out  1  one-cycle pulse after the FRAME_WORDS-th word
- frame_abort  out  1  one-cycle pulse when the trigger drops mid-frame
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; all counters, the shift register, synchronizer flops and every output are 0.
- trig_s is the synchronized trigger; trig_rise = trig_s & ~trig_s_d.
- States: IDLE, ALIGN, ACCUM.
  - IDLE → ALIGN on trig_rise.
  - ALIGN: wait for a rising edge of ref_subcarrier (ref=1, previous ref=0). The symbol starts on that cycle; go to ACCUM with sample_cnt=0.
  - ACCUM: each cycle, agree_cnt += (switch_signal ~^ ref_subcarrier) and sample_cnt++.
- Symbol decision, on the cycle where sample_cnt = SYMBOL_LEN-1 (that sample included):
  - A = final agreement total, width clog2(SYMBOL_LEN+1); it must not wrap.
  - A ≥ SYMBOL_LEN-MARGIN → bit 1.
  - A ≤ MARGIN → bit 0.
  - Otherwise → erasure. The bit is 1 if A > SYMBOL_LEN/2, else 0; an exact tie gives 0. The word's erasure accumulator is set.
  - Shift the bit in MSB-first. Clear agree_cnt and sample_cnt. The next symbol starts the next cycle with no re-alignment.
- Word completion: when the WORD_BITS-th bit is decided, data_word and word_erasure load on the following edge and word_valid pulses for one cycle (latency is 1 cycle after the final sample).
  - The bit counter and erasure accumulator then clear.
  - The word counter increments.
- Frame completion: after word FRAME_WORDS, frame_done pulses in the same cycle as that word's word_valid, and state returns to IDLE.
- Abort: trig_s=0 in ALIGN or ACCUM, frame not yet complete →
  - frame_abort pulses for one cycle and state goes to IDLE;
  - the partial word is discarded (no word_valid) and data_word keeps its last value.
- Simultaneous events:
  - Trigger fall on the same cycle as the final decision of the frame: frame_done wins and there is no abort.
  - Trigger fall on the same cycle as a non-final word completion: the word is emitted (word_valid=1), and frame_abort pulses in that same cycle.
- trig_rise while busy is ignored. A new frame needs trig_s to return to 0 and then rise.
- Outputs are registered; data_word holds between pulses.

Decomposition:
- Shared package: state enum (IDLE/ALIGN/ACCUM); clog2-derived widths CNT_W, BIT_W, WORD_CNT_W; a decision-threshold function.
- One natural sub-module: symbol_correlator, containing the agree/sample counters and the threshold decision. Its outputs are bit_valid, bit_value and bit_erasure.
- The FSM, packing and synchronizer stay in the top.

Test Plan:
- Clean frame 0xA5,0x3C,0xFF,0x00 (ideal phase-flipped subcarrier, defaults) → 4 word_valid pulses with those values, word_erasure=0, frame_done coincides with the 4th word_valid, busy drops on the next cycle.
- Symbol with 20 of 64 samples corrupted (A=44) → bit decided 1, word_erasure=1. With A=32 → bit 0, erasure=1. With A=48 → bit 1, erasure=0.
- Trigger drops after 13 bits → frame_abort pulse; exactly 1 word_valid was seen (word 0); data_word holds word 0; busy=0.
- Trigger rises while the reference is high → ACCUM starts on the next reference rising edge. A second trig_rise during the frame has no effect.
- Reset asserted mid-ACCUM → all outputs 0 immediately (asynchronous). After release, a full clean frame decodes correctly.
- Trigger deasserted on the exact final-decision cycle → frame_done=1, frame_abort=0.
